// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver for 8N1 frames (8E1 when UART_RX_PARITY_EN is defined)
//
// Oversamples the serial line on clk_baud (OVERSAMPLE ticks per bit), finds the
// start edge, samples each bit at its centre and presents the byte on bus_out
// with a one-cycle data_valid strobe.
//
// Parameters:
//   OVERSAMPLE  clk_baud ticks per serial bit; must be even and >= 4.
//
// Ports:
//   clk_baud    in   sampling clock, OVERSAMPLE x bit rate
//   rst         in   asynchronous reset, active low
//   rx_in       in   serial line, idle high, LSB first
//   bus_out     out  [7:0] last correctly framed byte, held until the next one
//   data_valid  out  one-cycle pulse when bus_out has just been updated
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   parity_err  out  one-cycle pulse on even-parity mismatch (0 without parity)
//
// Build option:
//   UART_RX_PARITY_EN  when defined, a parity bit (even) follows the data bits.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_baud,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] bus_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction
`endif

  logic             sync1_q;
  logic             rxs_q;       // synchronized line (rxs)
  logic             rxs_prev_q;  // rxs one cycle earlier, for 1->0 detection
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       bus_q;
  logic             dv_q;
  logic             fe_q;
`ifdef UART_RX_PARITY_EN
  logic             par_pend_q;  // parity mismatch seen, reported at stop bit
  logic             pe_q;
`endif

  // Two-flop synchronizer plus a delayed copy used for start-edge detection.
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_in;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Receive state machine with registered byte and status pulses.
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      bus_q      <= 8'h00;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_q <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          // Edge-triggered so a line held low (break) never re-arms.
          if (rxs_prev_q && !rxs_q) begin
            state_q <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
            par_pend_q <= 1'b0;
`endif
            // A line back high at mid start bit was only a glitch.
            if (rxs_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rxs_q, shift_q[7:1]};  // LSB arrives first
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q      <= '0;
            par_pend_q <= rxs_q ^ even_parity(shift_q);
            state_q    <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif

        S_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            // Back to IDLE at mid stop bit so a start edge in its second
            // half is already seen.
            state_q <= S_IDLE;
            if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
              if (par_pend_q) begin
                pe_q <= 1'b1;
              end else begin
                bus_q <= shift_q;
                dv_q  <= 1'b1;
              end
`else
              bus_q <= shift_q;
              dv_q  <= 1'b1;
`endif
            end else begin
              fe_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus_out    = bus_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
